bmr_tdee_sw_conditioner: RTL and testbench
==========================================

// Module: bmr_tdee_sw_conditioner
// PURPOSE
//  Conditions the raw slide-switch inputs before they reach the Qsys switch PIO in_port.
//  Per bit, it synchronises the asynchronous pin into clk, debounces it with a stability
//  counter, and emits one-cycle rise/fall pulses. Sits between the FPGA switch pins and
//  the PIO. sw_out drives the PIO in_port directly; the pulses feed optional edge logic.
// PARAMETERS
//  WIDTH            4        number of switch bits
//  DEBOUNCE_CYCLES  500000   clk cycles a synced level must hold before it is accepted (10 ms @ 50 MHz); legal >= 1
//  CNT_W            20       counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  SYNC_STAGES      2        synchroniser flops per bit; legal >= 2
// PORTS
//  clk         in   1      system clock (Qsys clk domain)
//  reset_n     in   1      asynchronous, active-low reset
//  sw_raw      in   WIDTH  raw switch pins, asynchronous to clk
//  sw_out      out  WIDTH  debounced level; connects to PIO in_port
//  sw_rise     out  WIDTH  1-cycle pulse when sw_out[i] goes 0->1
//  sw_fall     out  WIDTH  1-cycle pulse when sw_out[i] goes 1->0
//  sw_changed  out  1      1-cycle pulse, OR of all rise|fall bits in the same cycle
// BEHAVIOUR
//  - Reset: reset_n=0 asynchronously clears all sync flops, counters, sw_out, sw_rise,
//    sw_fall and sw_changed to 0. All outputs are registered.
//  - Sync: sw_raw[i] passes through SYNC_STAGES flops and produces s[i]. There is no
//    other logic between these flops.
//  - Debounce per bit, on each clk:
//      s[i]==sw_out[i]                   : cnt[i] <= 0.
//      s[i]!=sw_out[i], cnt<DEBOUNCE_CYCLES-1 : cnt[i] <= cnt[i]+1.
//      s[i]!=sw_out[i], cnt==DEBOUNCE_CYCLES-1: sw_out[i] <= s[i], cnt[i] <= 0, and the
//        matching rise/fall bit = 1 for exactly the next cycle.
//  - Latency: a clean step on sw_raw reaches sw_out after SYNC_STAGES+DEBOUNCE_CYCLES clk
//    edges (+/-1 for pin metastability). Pulses are asserted in the same cycle that
//    sw_out changes.
//  - Glitch: if s[i] returns to sw_out[i] before the count completes, cnt[i] clears and
//    there is no output change and no pulse. A later disagreement restarts the count from 0.
//  - Counter never wraps. It saturates by construction because it is cleared on accept.
//  - Bits are independent. Simultaneous changes on several bits give simultaneous
//    pulses and a single sw_changed cycle.
//  - Rise and fall on the same bit are mutually exclusive in any one cycle.
//  - Post-reset: sw_out is 0. A switch held high through reset is accepted after the
//    debounce time and produces a sw_rise pulse. This is intended: software sees the
//    initial state as an edge.
//  - Reset asserted mid-count: count is lost and outputs clear immediately. Debounce
//    restarts from 0 after release.
//  - DEBOUNCE_CYCLES==1: a change is accepted on the first cycle of disagreement.
// STRUCTURE
//  - Shared package bmr_tdee_pkg holds CLK_HZ=50_000_000, SW_DEBOUNCE_MS=10 and
//    SW_WIDTH=4. It also holds the function clog2_f used to derive CNT_W at the top level.
//  - One sub-module, bmr_tdee_debounce_bit, contains the sync chain, counter,
//    level register and rise/fall registers for one bit. It is instantiated WIDTH
//    times with a generate loop.
//  - Top level builds sw_changed = |(sw_rise|sw_fall), registered one level from the
//    bit outputs so that it aligns with them. It must not lag them.
// TESTING  (sim: DEBOUNCE_CYCLES=8, SYNC_STAGES=2, WIDTH=4)
//  1 Reset with sw_raw=4'hF -> all outputs 0 during reset. After release, sw_out=4'hF
//    at edge 2+8, with sw_rise=4'hF and sw_changed=1 for that one cycle.
//  2 sw_raw[0] 0->1 held -> sw_out[0]=1 exactly 10 edges later, one sw_rise[0] pulse,
//    sw_fall=0.
//  3 sw_raw[2] 5-cycle high glitch -> sw_out and pulses unchanged. Then hold high for
//    12 cycles -> accepted 10 edges after the hold starts.
//  4 sw_raw 4'h0->4'h5 in one cycle -> sw_rise=4'h5 in one cycle and a single
//    sw_changed pulse. Then 4'h5->4'hA -> sw_fall=4'h5 and sw_rise=4'hA in the same cycle.
//  5 Assert reset_n at count 5 of a 0->1 transition -> sw_out stays 0 and cnt clears.
//    After release, a full 10 edges is needed before sw_out[i]=1.
//  6 Random sw_raw toggling against a reference model for 10k cycles -> sw_out never
//    changes while sw_raw is unstable for less than 8 cycles. Pulses are always 1 cycle
//    wide and coincide with sw_out changes.

Source files
------------

// File: rtl/bmr_tdee_pkg.sv
// Shared constants and helpers for the board's front-end conditioning blocks.
//   CLK_HZ             system clock frequency
//   SW_DEBOUNCE_MS     switch debounce window in milliseconds
//   SW_WIDTH           number of slide switches
//   SW_DEBOUNCE_CYCLES debounce window expressed in clk cycles
//   edge_e             kind of level change accepted on one switch bit
//   clog2_f            ceiling log2, usable in parameter expressions
package bmr_tdee_pkg;

    localparam int unsigned CLK_HZ             = 50_000_000;
    localparam int unsigned SW_DEBOUNCE_MS     = 10;
    localparam int unsigned SW_WIDTH           = 4;
    localparam int unsigned SW_DEBOUNCE_CYCLES = CLK_HZ / 1000 * SW_DEBOUNCE_MS;

    typedef enum logic [1:0] {
        EdgeNone,
        EdgeRise,
        EdgeFall
    } edge_e;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bmr_tdee_sw_conditioner_if.sv
// Switch conditioner bundle: raw pins in, debounced level and edge pulses out.
//   sw_raw      raw switch pins, asynchronous to clk
//   sw_out      debounced level (feeds the PIO in_port)
//   sw_rise     one-cycle pulse per bit on a 0->1 accept
//   sw_fall     one-cycle pulse per bit on a 1->0 accept
//   sw_changed  one-cycle pulse when any bit rises or falls
// Modports: master drives the pins and observes the results; slave is the conditioner.
interface bmr_tdee_sw_conditioner_if
    import bmr_tdee_pkg::*;
#(
    parameter int unsigned WIDTH = SW_WIDTH
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    modport master (
        output sw_raw,
        input  sw_out,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    modport slave (
        input  sw_raw,
        output sw_out,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );

endinterface

// File: rtl/bmr_tdee_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter, accepted level and edge pulses.
//   clk, reset_n  system clock, asynchronous active-low reset
//   sw_raw        raw pin, asynchronous to clk
//   sw_out        accepted (debounced) level, registered
//   sw_rise       registered one-cycle pulse on a 0->1 accept
//   sw_fall       registered one-cycle pulse on a 1->0 accept
//   accept_next   combinational: an accept happens on the coming edge
// Legal ranges: DEBOUNCE_CYCLES >= 1, SYNC_STAGES >= 2, 2**CNT_W > DEBOUNCE_CYCLES.
module bmr_tdee_debounce_bit
    import bmr_tdee_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_out,
    output logic sw_rise,
    output logic sw_fall,
    output logic accept_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, fall_q;
    edge_e                  edge_d;

    // Pure shift chain: nothing may sit between these flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The counter only runs while the synced level disagrees with the accepted one and is
    // cleared on accept, so it never exceeds CNT_LAST.
    always_comb begin
        cnt_d       = '0;
        out_d       = out_q;
        edge_d      = EdgeNone;
        accept_next = 1'b0;
        if (sync_s != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d       = sync_s;
                accept_next = 1'b1;
                edge_d      = sync_s ? EdgeRise : EdgeFall;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= (edge_d == EdgeRise);
            fall_q <= (edge_d == EdgeFall);
        end
    end

    assign sw_out  = out_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;

endmodule

// File: rtl/bmr_tdee_sw_conditioner.sv
// Conditions the slide-switch pins ahead of the switch PIO: per-bit synchronise, debounce
// and edge detection, plus a combined change pulse.
//   clk, reset_n  system clock, asynchronous active-low reset
//   sw            slave side of the switch bundle (sw_raw in; sw_out, sw_rise, sw_fall,
//                 sw_changed out; all outputs registered)
module bmr_tdee_sw_conditioner
    import bmr_tdee_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = clog2_f(DEBOUNCE_CYCLES) + 1,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    bmr_tdee_sw_conditioner_if.slave      sw
);

    logic [WIDTH-1:0] out_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] accept_w;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bmr_tdee_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_bit (
            .clk         (clk),
            .reset_n     (reset_n),
            .sw_raw      (sw.sw_raw[i]),
            .sw_out      (out_w[i]),
            .sw_rise     (rise_w[i]),
            .sw_fall     (fall_w[i]),
            .accept_next (accept_w[i])
        );
    end

    // Registered from the per-bit accept strobes (the rise/fall next-state), so it lands in
    // the same cycle as the rise/fall pulses rather than one behind them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |accept_w;
        end
    end

    assign sw.sw_out     = out_w;
    assign sw.sw_rise    = rise_w;
    assign sw.sw_fall    = fall_w;
    assign sw.sw_changed = changed_q;

endmodule

// File: tb/tb_bmr_tdee_sw_conditioner.sv
module tb_bmr_tdee_sw_conditioner;

    localparam int unsigned W  = 4;
    localparam int unsigned DB = 8;

    logic clk;
    logic reset_n;
    int   n_asserts;
    int   n_fail;

    bmr_tdee_sw_conditioner_if #(.WIDTH(W)) sw_if ();

    bmr_tdee_sw_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_out, input logic [3:0] e_rise,
                           input logic [3:0] e_fall, input logic e_chg);
        chk({tag, ".out"},  8'(sw_if.sw_out),     8'(e_out));
        chk({tag, ".rise"}, 8'(sw_if.sw_rise),    8'(e_rise));
        chk({tag, ".fall"}, 8'(sw_if.sw_fall),    8'(e_fall));
        chk({tag, ".chg"},  8'(sw_if.sw_changed), 8'(e_chg));
    endtask

    // Reference model state for the random phase
    logic [3:0] m_s1, m_s2, m_out, m_rise, m_fall;
    int         m_cnt [4];

    initial begin
        logic [3:0] nr;
        n_asserts = 0;
        n_fail    = 0;

        // 1: reset with switches high, then accept as an initial rise
        reset_n      = 1'b0;
        sw_if.sw_raw = 4'hF;
        repeat (3) tick();
        chk_all("t1.in_reset", 4'h0, 4'h0, 4'h0, 1'b0);
        reset_n = 1'b1;
        repeat (9) tick();
        chk("t1.edge9.out", 8'(sw_if.sw_out), 8'h0);
        tick();
        chk_all("t1.edge10", 4'hF, 4'hF, 4'h0, 1'b1);
        tick();
        chk_all("t1.edge11", 4'hF, 4'h0, 4'h0, 1'b0);
        sw_if.sw_raw = 4'h0;
        repeat (10) tick();
        chk_all("t1.fall_all", 4'h0, 4'h0, 4'hF, 1'b1);

        // 2: single bit rise
        sw_if.sw_raw = 4'h1;
        repeat (9) tick();
        chk("t2.edge9.out", 8'(sw_if.sw_out), 8'h0);
        tick();
        chk_all("t2.edge10", 4'h1, 4'h1, 4'h0, 1'b1);
        tick();
        chk_all("t2.edge11", 4'h1, 4'h0, 4'h0, 1'b0);

        // 3: 5-cycle glitch on bit 2 is rejected, then a real hold is accepted
        sw_if.sw_raw = 4'h5;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) sw_if.sw_raw = 4'h1;
            tick();
            chk("t3.glitch.out",  8'(sw_if.sw_out),     8'h1);
            chk("t3.glitch.rise", 8'(sw_if.sw_rise),    8'h0);
            chk("t3.glitch.chg",  8'(sw_if.sw_changed), 8'h0);
        end
        sw_if.sw_raw = 4'h5;
        repeat (9) tick();
        chk("t3.edge9.out", 8'(sw_if.sw_out), 8'h1);
        tick();
        chk_all("t3.edge10", 4'h5, 4'h4, 4'h0, 1'b1);
        repeat (2) tick();
        chk_all("t3.hold", 4'h5, 4'h0, 4'h0, 1'b0);

        // 4: multi-bit simultaneous changes
        sw_if.sw_raw = 4'h0;
        repeat (10) tick();
        chk_all("t4.clear", 4'h0, 4'h0, 4'h5, 1'b1);
        tick();
        sw_if.sw_raw = 4'h5;
        repeat (10) tick();
        chk_all("t4.rise5", 4'h5, 4'h5, 4'h0, 1'b1);
        tick();
        chk_all("t4.rise5.after", 4'h5, 4'h0, 4'h0, 1'b0);
        sw_if.sw_raw = 4'hA;
        repeat (10) tick();
        chk_all("t4.swapA", 4'hA, 4'hA, 4'h5, 1'b1);
        tick();
        chk_all("t4.swapA.after", 4'hA, 4'h0, 4'h0, 1'b0);

        // 5: reset mid-count clears immediately; full window needed afterwards
        sw_if.sw_raw = 4'hB;
        repeat (7) tick();
        chk("t5.count5.out", 8'(sw_if.sw_out), 8'hA);
        reset_n = 1'b0;
        #1;
        chk_all("t5.async_clr", 4'h0, 4'h0, 4'h0, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (9) tick();
        chk("t5.edge9.out", 8'(sw_if.sw_out), 8'h0);
        tick();
        chk_all("t5.edge10", 4'hB, 4'hB, 4'h0, 1'b1);
        tick();
        chk_all("t5.edge11", 4'hB, 4'h0, 4'h0, 1'b0);

        // 6: random toggling against a cycle model
        m_s1  = 4'hB;
        m_s2  = 4'hB;
        m_out = 4'hB;
        for (int b = 0; b < 4; b++) m_cnt[b] = 0;
        nr = 4'hB;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 11) == 0) nr[b] = ~nr[b];
            end
            sw_if.sw_raw = nr;
            m_rise = 4'h0;
            m_fall = 4'h0;
            for (int b = 0; b < 4; b++) begin
                if (m_s2[b] == m_out[b]) begin
                    m_cnt[b] = 0;
                end else if (m_cnt[b] == int'(DB) - 1) begin
                    m_cnt[b] = 0;
                    m_out[b] = m_s2[b];
                    if (m_s2[b]) m_rise[b] = 1'b1;
                    else         m_fall[b] = 1'b1;
                end else begin
                    m_cnt[b] = m_cnt[b] + 1;
                end
            end
            m_s2 = m_s1;
            m_s1 = nr;
            tick();
            chk_all("t6.rand", m_out, m_rise, m_fall, |(m_rise | m_fall));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
